multi_channel_synchronizer: RTL

//   Brings WIDTH independent asynchronous 1-bit inputs into the clk domain.

---
 rtl/sync_pkg.sv | 11 +
 rtl/sync_channel.sv | 75 +++++++
 rtl/multi_channel_synchronizer.sv | 38 +++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for clock-domain synchroniser blocks.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    // Width of a counter that must hold values 0..cycles.
    function automatic int sync_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_channel.sv
// One synchroniser channel: STAGES-deep flop chain, optional stability filter
// (SYNC_GLITCH_FILTER_EN) and registered level with one-cycle edge pulses.
module sync_channel
    import sync_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_channel: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_channel: FILTER_CYCLES must be at least 1");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic s_last;
    logic load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_in};
        end
    end

    assign s_last = sync_q[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int              CW       = sync_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The output only moves once s_last has disagreed for FILTER_CYCLES edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s_last != data_out) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign load = (s_last != data_out) && (cnt == CNT_LAST);
`else
    assign load = (s_last != data_out);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= INIT_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= load &  s_last;
            fall_pulse <= load & ~s_last;
            if (load) begin
                data_out <= s_last;
            end
        end
    end

endmodule

// File: rtl/multi_channel_synchronizer.sv
// WIDTH independent 1-bit synchronisers with edge pulses and a change flag.
// Optional stability filter selected by SYNC_GLITCH_FILTER_EN.
module multi_channel_synchronizer
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_channel #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .INIT_VAL      (INIT_VAL[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .data_in    (data_in[i]),
            .data_out   (data_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    // Pulses are already registered, so this is aligned with them.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule
